// File: rtl/instruction_loader.sv
// Loads a session of instruction words into a byte-wide memory, big-endian, from a word-aligned base.
// Latency: byte writes on the 4 cycles after each accept; o_Done one cycle after the last byte.
// Backpressure: o_Word_Ready is high only while waiting for a word; throughput 1 word per 5 cycles.
module instruction_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Start,
    input  logic [ADDR_WIDTH-1:0] i_Base_Address,
    input  logic                  i_Word_Valid,
    input  logic [DATA_WIDTH-1:0] i_Word,
    input  logic                  i_Last,
    output logic                  o_Word_Ready,
    output logic                  o_Mem_We,
    output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
    output logic [7:0]            o_Mem_Byte,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Error,
    output logic [ADDR_WIDTH-2:0] o_Word_Count
);

    typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic                    last_q, last_d;
    logic                    ready_d, we_d, busy_d, done_d, err_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [7:0]              byte_d;
    logic [ADDR_WIDTH-2:0]   cnt_d;
    logic [ADDR_WIDTH:0]     ptr_sum;

    // Carry out of the pointer increment marks a session running off the end of the store.
    assign ptr_sum = {1'b0, ptr_q} + (ADDR_WIDTH+1)'(4);

    function automatic logic [7:0] byte_sel(input logic [DATA_WIDTH-1:0] w, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        last_d  = last_q;
        ready_d = 1'b0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = o_Error;
        addr_d  = o_Mem_Addr;
        byte_d  = o_Mem_Byte;
        cnt_d   = o_Word_Count;
        case (state_q)
            IDLE: begin
                if (i_Start) begin
                    if (i_Base_Address[1:0] == 2'b00) begin
                        ptr_d   = i_Base_Address;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = WAIT_WORD;
                        ready_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_WORD: begin
                busy_d  = 1'b1;
                ready_d = 1'b1;
                if (i_Word_Valid && o_Word_Ready) begin
                    word_d  = i_Word;
                    last_d  = i_Last;
                    idx_d   = 2'd0;
                    state_d = WRITE;
                    ready_d = 1'b0;
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    byte_d  = byte_sel(i_Word, 2'd0);
                end
            end
            WRITE: begin
                busy_d = 1'b1;
                if (idx_q == 2'd3) begin
                    ptr_d = ptr_sum[ADDR_WIDTH-1:0];
                    cnt_d = o_Word_Count + (ADDR_WIDTH-1)'(1);
                    if (last_q || ptr_sum[ADDR_WIDTH]) begin
                        err_d   = o_Error | (~last_q);
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = WAIT_WORD;
                        ready_d = 1'b1;
                    end
                end else begin
                    idx_d  = idx_q + 2'd1;
                    we_d   = 1'b1;
                    addr_d = ptr_q + ADDR_WIDTH'(idx_d);
                    byte_d = byte_sel(word_q, idx_d);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ptr_q        <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
            o_Word_Ready <= 1'b0;
            o_Mem_We     <= 1'b0;
            o_Mem_Addr   <= '0;
            o_Mem_Byte   <= '0;
            o_Busy       <= 1'b0;
            o_Done       <= 1'b0;
            o_Error      <= 1'b0;
            o_Word_Count <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            word_q       <= word_d;
            last_q       <= last_d;
            o_Word_Ready <= ready_d;
            o_Mem_We     <= we_d;
            o_Mem_Addr   <= addr_d;
            o_Mem_Byte   <= byte_d;
            o_Busy       <= busy_d;
            o_Done       <= done_d;
            o_Error      <= err_d;
            o_Word_Count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomised bench for instruction_loader against a byte-level reference model of a load session.
module tb_instruction_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_Start = 1'b0;
    logic [9:0] i_Base_Address = '0;
    logic       i_Word_Valid = 1'b0;
    logic [31:0] i_Word = '0;
    logic       i_Last = 1'b0;
    logic       o_Word_Ready, o_Mem_We, o_Busy, o_Done, o_Error;
    logic [9:0] o_Mem_Addr;
    logic [7:0] o_Mem_Byte;
    logic [8:0] o_Word_Count;

    always #5 clk = ~clk;

    instruction_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .i_Start(i_Start), .i_Base_Address(i_Base_Address),
        .i_Word_Valid(i_Word_Valid), .i_Word(i_Word), .i_Last(i_Last),
        .o_Word_Ready(o_Word_Ready), .o_Mem_We(o_Mem_We), .o_Mem_Addr(o_Mem_Addr),
        .o_Mem_Byte(o_Mem_Byte), .o_Busy(o_Busy), .o_Done(o_Done), .o_Error(o_Error),
        .o_Word_Count(o_Word_Count)
    );

    int checks = 0;
    int errors = 0;

    // Monitor: everything observed mid-cycle.
    int cyc = 0;
    int rdy_cnt = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0;
    int wa[$], wb[$], wc[$];

    always @(negedge clk) begin
        cyc++;
        if (o_Mem_We) begin
            wa.push_back(int'(o_Mem_Addr));
            wb.push_back(int'(o_Mem_Byte));
            wc.push_back(cyc);
        end
        if (o_Word_Ready) rdy_cnt++;
        if (o_Busy) busy_cnt++;
        if (o_Done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Reference model: expected byte writes and final status of one session.
    logic [31:0] words [16];
    int ea[$], eb[$];
    int exp_cnt, exp_acc;
    bit exp_err;

    function automatic void model(input int base, input int n, input int last_at);
        int ptr = base;
        ea.delete(); eb.delete();
        exp_cnt = 0; exp_acc = 0; exp_err = 0;
        for (int i = 0; i < n; i++) begin
            exp_acc++;
            for (int k = 0; k < 4; k++) begin
                ea.push_back(ptr + k);
                eb.push_back(int'((words[i] >> (24 - 8 * k)) & 32'hFF));
            end
            exp_cnt++;
            if (i == last_at) break;
            if (ptr + 4 > 1023) begin
                exp_err = 1;
                break;
            end
            ptr += 4;
        end
    endfunction

    task automatic clear_mon();
        wa.delete(); wb.delete(); wc.delete();
        rdy_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    endtask

    // Called just after a rising edge; returns just after a rising edge with the DUT back in IDLE.
    task automatic do_session(input int base, input int n, input int last_at, input bit glitch,
                              output bit got_done, output int acc_n);
        int  k = 0;
        bit  acc;
        got_done = 0;
        acc_n = 0;
        i_Start = 1'b1;
        i_Base_Address = base[9:0];
        @(posedge clk); #1;
        i_Start = 1'b0;
        i_Word_Valid = 1'b1;
        i_Word = words[0];
        i_Last = (last_at == 0);
        for (int t = 0; t < 200 && !got_done; t++) begin
            @(negedge clk);
            if (o_Done) begin
                got_done = 1;
            end else begin
                acc = o_Word_Ready && i_Word_Valid;
                @(posedge clk); #1;
                i_Start = glitch && (wa.size() == 1);
                if (i_Start) i_Base_Address = 10'd100;
                if (acc) begin
                    acc_n++;
                    k++;
                    if (k < n) begin
                        i_Word = words[k];
                        i_Last = (k == last_at);
                    end else begin
                        i_Word_Valid = 1'b0;
                    end
                end
            end
        end
        i_Word_Valid = 1'b0;
        i_Last = 1'b0;
        i_Start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_Mem_We, o_Word_Ready, o_Busy, o_Done, o_Error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=00000", {o_Mem_We, o_Word_Ready, o_Busy, o_Done, o_Error});
        end
        checks++;
        if ({o_Word_Count, o_Mem_Addr, o_Mem_Byte} !== 27'd0) begin
            errors++;
            $display("FAIL reset_values cnt=%0d addr=%0d byte=%0h want all 0", o_Word_Count, o_Mem_Addr, o_Mem_Byte);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Start issued on the very first cycle after reset release.
    task automatic test_single_word();
        bit gd; int acc_n;
        words[0] = 32'hE3A00014;
        model(0, 1, 0);
        clear_mon();
        do_session(0, 1, 0, 0, gd, acc_n);
        checks++;
        if (!gd) begin errors++; $display("FAIL single_done_timeout got=0 want=1"); end
        checks++;
        if (wa.size() != 4) begin errors++; $display("FAIL single_nwrites got=%0d want=4", wa.size()); end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] != ea[i] || wb[i] != eb[i]) begin
                errors++;
                $display("FAIL single_write%0d got=(%0d,%0h) want=(%0d,%0h)", i, wa[i], wb[i], ea[i], eb[i]);
            end
        end
        if (wa.size() == 4) begin
            checks++;
            if (wb[0] != 'hE3 || wb[3] != 'h14) begin errors++; $display("FAIL single_endian got=%0h,%0h want=e3,14", wb[0], wb[3]); end
            checks++;
            if (wc[3] - wc[0] != 3) begin errors++; $display("FAIL single_consecutive span=%0d want=3", wc[3] - wc[0]); end
            checks++;
            if (done_cyc != wc[3] + 1) begin errors++; $display("FAIL single_done_cycle got=%0d want=%0d", done_cyc, wc[3] + 1); end
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL single_done_pulses got=%0d want=1", done_cnt); end
        checks++;
        if (o_Word_Count !== 9'd1 || o_Error !== 1'b0) begin
            errors++;
            $display("FAIL single_status cnt=%0d err=%b want cnt=1 err=0", o_Word_Count, o_Error);
        end
    endtask

    task automatic test_multi_word();
        bit gd; int acc_n;
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        model(8, 3, 2);
        clear_mon();
        do_session(8, 3, 2, 0, gd, acc_n);
        checks++;
        if (!gd || wa.size() != 12) begin errors++; $display("FAIL multi_writes done=%0d n=%0d want done=1 n=12", gd, wa.size()); end
        for (int i = 0; i < 12 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] != ea[i] || wb[i] != eb[i]) begin
                errors++;
                $display("FAIL multi_write%0d got=(%0d,%0h) want=(%0d,%0h)", i, wa[i], wb[i], ea[i], eb[i]);
            end
        end
        checks++;
        if (rdy_cnt != 3) begin errors++; $display("FAIL multi_ready_cycles got=%0d want=3", rdy_cnt); end
        if (wc.size() == 12) begin
            checks++;
            if (wc[4] - wc[0] != 5 || wc[8] - wc[4] != 5) begin
                errors++;
                $display("FAIL multi_throughput gaps=%0d,%0d want=5,5", wc[4] - wc[0], wc[8] - wc[4]);
            end
        end
        checks++;
        if (o_Word_Count !== 9'd3 || o_Error !== 1'b0) begin
            errors++;
            $display("FAIL multi_status cnt=%0d err=%b want cnt=3 err=0", o_Word_Count, o_Error);
        end
    endtask

    task automatic test_misaligned();
        clear_mon();
        i_Start = 1'b1;
        i_Base_Address = 10'h002;
        @(posedge clk); #1;
        i_Start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (o_Error !== 1'b1) begin errors++; $display("FAIL misaligned_error got=%b want=1", o_Error); end
        checks++;
        if (wa.size() != 0 || busy_cnt != 0) begin
            errors++;
            $display("FAIL misaligned_activity writes=%0d busy=%0d want 0,0", wa.size(), busy_cnt);
        end
    endtask

    task automatic test_overrun();
        bit gd; int acc_n;
        words[0] = $urandom;
        words[1] = $urandom;
        model(1020, 2, 1);
        clear_mon();
        do_session(1020, 2, 1, 0, gd, acc_n);
        checks++;
        if (!gd || done_cnt != 1) begin errors++; $display("FAIL overrun_done got=%0d pulses=%0d want 1", gd, done_cnt); end
        checks++;
        if (wa.size() != ea.size()) begin errors++; $display("FAIL overrun_nwrites got=%0d want=%0d", wa.size(), ea.size()); end
        for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
            checks++;
            if (wa[i] != ea[i] || wb[i] != eb[i]) begin
                errors++;
                $display("FAIL overrun_write%0d got=(%0d,%0h) want=(%0d,%0h)", i, wa[i], wb[i], ea[i], eb[i]);
            end
        end
        checks++;
        if (acc_n != exp_acc) begin errors++; $display("FAIL overrun_accepted got=%0d want=%0d", acc_n, exp_acc); end
        checks++;
        if (o_Error !== exp_err || int'(o_Word_Count) != exp_cnt) begin
            errors++;
            $display("FAIL overrun_status err=%b cnt=%0d want err=%0d cnt=%0d", o_Error, o_Word_Count, exp_err, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_write();
        bit hit = 0;
        clear_mon();
        i_Start = 1'b1;
        i_Base_Address = 10'd16;
        @(posedge clk); #1;
        i_Start = 1'b0;
        i_Word_Valid = 1'b1;
        i_Word = $urandom;
        i_Last = 1'b1;
        for (int t = 0; t < 20 && !hit; t++) begin
            @(negedge clk);
            if (o_Mem_We && o_Mem_Addr == 10'd18) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rstmid_timeout got=no write at 18 want=write at 18");
        end else begin
            reset = 1'b1;
            i_Word_Valid = 1'b0;
            i_Last = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (o_Mem_We !== 1'b0 || o_Busy !== 1'b0 || o_Word_Count !== 9'd0) begin
                errors++;
                $display("FAIL rstmid_abort we=%b busy=%b cnt=%0d want 0,0,0", o_Mem_We, o_Busy, o_Word_Count);
            end
            @(posedge clk); #1;
            reset = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            checks++;
            if (wa.size() != 3 || wa[wa.size()-1] != 18) begin
                errors++;
                $display("FAIL rstmid_writes n=%0d want=3 ending at 18", wa.size());
            end
        end
    endtask

    task automatic test_ignored_inputs();
        bit gd; int acc_n;
        clear_mon();
        i_Word_Valid = 1'b1;
        i_Word = $urandom;
        repeat (4) @(posedge clk);
        #1;
        i_Word_Valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rdy_cnt != 0 || wa.size() != 0 || busy_cnt != 0) begin
            errors++;
            $display("FAIL idle_valid ready=%0d writes=%0d busy=%0d want 0,0,0", rdy_cnt, wa.size(), busy_cnt);
        end
        words[0] = $urandom;
        words[1] = $urandom;
        model(40, 2, 1);
        clear_mon();
        do_session(40, 2, 1, 1, gd, acc_n);
        checks++;
        if (!gd || wa.size() != 8) begin errors++; $display("FAIL glitch_writes done=%0d n=%0d want 1,8", gd, wa.size()); end
        for (int i = 0; i < 8 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] != ea[i] || wb[i] != eb[i]) begin
                errors++;
                $display("FAIL glitch_write%0d got=(%0d,%0h) want=(%0d,%0h)", i, wa[i], wb[i], ea[i], eb[i]);
            end
        end
    endtask

    task automatic test_random_sessions();
        bit gd; int acc_n, base, n, bad;
        for (int s = 0; s < 10; s++) begin
            base = int'($urandom_range(0, 255)) * 4;
            if (s % 3 == 2) base = 1024 - 4 * int'($urandom_range(1, 2));
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) words[i] = $urandom;
            model(base, n, n - 1);
            clear_mon();
            do_session(base, n, n - 1, 0, gd, acc_n);
            bad = 0;
            if (wa.size() != ea.size()) bad++;
            for (int i = 0; i < wa.size() && i < ea.size(); i++)
                if (wa[i] != ea[i] || wb[i] != eb[i]) bad++;
            checks++;
            if (!gd || bad != 0) begin
                errors++;
                $display("FAIL rand%0d_writes base=%0d done=%0d mismatches=%0d want done=1 mismatches=0", s, base, gd, bad);
            end
            checks++;
            if (int'(o_Word_Count) != exp_cnt || o_Error !== exp_err || acc_n != exp_acc) begin
                errors++;
                $display("FAIL rand%0d_status cnt=%0d err=%b acc=%0d want %0d,%0d,%0d",
                         s, o_Word_Count, o_Error, acc_n, exp_cnt, exp_err, exp_acc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_word();
        test_misaligned();
        test_overrun();
        test_reset_mid_write();
        test_ignored_inputs();
        test_random_sessions();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, byte address width (1024-byte instruction store).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_Start  input  1  begin a load session at i_Base_Address (sampled in IDLE only).
REQ-006 SHALL have port i_Base_Address  input  ADDR_WIDTH  first byte address of session; must be word-aligned.
REQ-007 SHALL have port i_Word_Valid  input  1  producer presents a word.
REQ-008 SHALL have port i_Word  input  DATA_WIDTH  instruction word to store.
REQ-009 SHALL have port i_Last  input  1  qualifies i_Word as final word of session.
REQ-010 SHALL have port o_Word_Ready  output  1  loader accepts i_Word this cycle.
REQ-011 SHALL have ports o_Mem_We (1), o_Mem_Addr (ADDR_WIDTH), o_Mem_Byte (8)  outputs  byte write port toward instruction memory.
REQ-012 SHALL have ports o_Busy (1), o_Done (1), o_Error (1), o_Word_Count (ADDR_WIDTH-1)  outputs  status.

Function
REQ-013 SHALL implement states IDLE, WAIT_WORD, WRITE, DONE; all outputs driven from registers.
REQ-014 IDLE: o_Word_Ready=0, o_Busy=0; i_Start=1 with i_Base_Address[1:0]=00 -> latch pointer, clear o_Word_Count and o_Error, go WAIT_WORD.
REQ-015 IDLE: i_Start=1 with i_Base_Address[1:0]!=00 -> set o_Error=1, no writes, remain IDLE.
REQ-016 i_Start outside IDLE SHALL be ignored; i_Word_Valid outside WAIT_WORD SHALL be ignored.
REQ-017 WAIT_WORD: o_Word_Ready=1, o_Busy=1; transfer occurs when i_Word_Valid and o_Word_Ready both high; capture i_Word, i_Last; go WRITE with byte index 0.
REQ-018 WRITE: exactly 4 cycles, o_Mem_We=1, o_Mem_Addr=pointer+index, o_Mem_Byte=word bits [31-8*index : 24-8*index] (big-endian: MSB at lowest address); o_Word_Ready=0.
REQ-019 Byte writes SHALL occur in the 4 cycles immediately following the accept cycle; throughput 1 word per 5 cycles.
REQ-020 After byte 3: pointer += 4, o_Word_Count += 1; captured last=1 -> DONE; else pointer wrapped past end of store -> set o_Error=1, go DONE; else WAIT_WORD.
REQ-021 Pointer SHALL never wrap into a write: no byte write at address below the session base after overrun.
REQ-022 DONE: o_Done=1 for exactly one cycle, o_Busy=0, then IDLE; o_Error and o_Word_Count hold until next valid i_Start or reset.
REQ-023 o_Mem_We SHALL be 0 in every state except WRITE; o_Mem_Addr/o_Mem_Byte hold last values when o_Mem_We=0.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE and all outputs to 0 on that edge, overriding all other inputs.
REQ-025 Reset during WRITE SHALL abort the word: o_Mem_We=0 from the next cycle, no remaining bytes written, count not incremented.
REQ-026 First i_Start SHALL be honoured on the cycle after reset deasserts.

Verification
REQ-027 Base 0, one word 0xE3A00014 with i_Last=1 -> writes (0,E3),(1,A0),(2,00),(3,14) on 4 consecutive cycles, o_Done pulse next cycle, o_Word_Count=1.
REQ-028 Base 8, three words valid held high, last on third -> addresses 8..19 in order, o_Word_Ready high 1 of every 5 cycles, o_Word_Count=3, o_Error=0.
REQ-029 i_Start with base 0x002 -> o_Error=1, o_Mem_We never asserted, o_Busy stays 0.
REQ-030 Base 1020, two words, first i_Last=0 -> bytes 1020..1023 written, o_Error=1, o_Done pulse, second word never accepted, no write to address 0.
REQ-031 Reset asserted on byte index 2 -> next cycle o_Mem_We=0, o_Busy=0, o_Word_Count=0; no write to base+3.
REQ-032 i_Start pulsed while in WRITE, and i_Word_Valid in IDLE -> both ignored; session addresses unchanged, o_Word_Ready stays 0 in IDLE.
